// File: rtl/tinyalu_pipe.sv
// Parametrised tiny ALU: single-cycle add/and/xor/sub/or/illegal, plus a
// MUL_STAGES-deep multiply pipeline guarded by a start/ready handshake.
module tinyalu_pipe #(
    parameter int WIDTH      = 8,
    parameter int MUL_STAGES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    output logic               ready,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] result,
    output logic               dbg_state
);

    // Handshake: a request transfers on a rising edge where start && ready
    // and op is not NOP; start while ready is low is simply not taken.

    localparam int RW = 2 * WIDTH;
    localparam int PD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int CW = (MUL_STAGES > 2) ? $clog2(MUL_STAGES - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          mul_accept;
    logic          pipe_mul;
    logic [RW-1:0] ext_a;
    logic [RW-1:0] ext_b;
    logic [RW-1:0] alu_res;
    logic          mul_out_vld;
    logic [RW-1:0] mul_out;

    assign ready      = (state == IDLE);
    assign dbg_state  = (state == MUL);
    assign accept     = start && ready && (op != OP_NOP);
    assign mul_accept = accept && (op == OP_MUL);
    assign pipe_mul   = (MUL_STAGES > 1);

    assign ext_a = {{WIDTH{1'b0}}, A};
    assign ext_b = {{WIDTH{1'b0}}, B};

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = ext_a + ext_b;
            OP_AND:  alu_res = ext_a & ext_b;
            OP_XOR:  alu_res = ext_a ^ ext_b;
            OP_MUL:  alu_res = ext_a * ext_b;
            OP_SUB:  alu_res = ext_a - ext_b;
            OP_OR:   alu_res = ext_a | ext_b;
            OP_ILL:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    // The output register is the final multiply stage, so the internal
    // pipeline holds only MUL_STAGES-1 stages.
    generate
        if (MUL_STAGES > 1) begin : g_mul_pipe
            logic [RW-1:0] pipe_prod [PD];
            logic [PD-1:0] pipe_vld;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_vld <= '0;
                    for (int i = 0; i < PD; i++) begin
                        pipe_prod[i] <= '0;
                    end
                end else begin
                    pipe_vld[0] <= mul_accept;
                    if (mul_accept) begin
                        pipe_prod[0] <= alu_res;
                    end
                    for (int i = 1; i < PD; i++) begin
                        pipe_vld[i]  <= pipe_vld[i-1];
                        pipe_prod[i] <= pipe_prod[i-1];
                    end
                end
            end

            assign mul_out_vld = pipe_vld[PD-1];
            assign mul_out     = pipe_prod[PD-1];
        end else begin : g_mul_comb
            assign mul_out_vld = 1'b0;
            assign mul_out     = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_accept && pipe_mul) begin
                        state <= MUL;
                        cnt   <= CNT_LOAD;
                    end
                end
                MUL: begin
                    // Counter reaches zero in the cycle before the product lands.
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (mul_out_vld) begin
                done   <= 1'b1;
                result <= mul_out;
            end else if (accept && !(op == OP_MUL && pipe_mul)) begin
                done   <= 1'b1;
                err    <= (op == OP_ILL);
                result <= alu_res;
            end
        end
    end

endmodule

// File: doc/tinyalu_pipe.md
# tinyalu_pipe

Parametrised successor ALU for the cocotb example designs: `WIDTH`-bit operands, a configurable-latency multiplier and a `start`/`ready` handshake. Operands are captured at acceptance. The block adds subtract, OR and an error flag for illegal opcodes. It sits where the fixed 8-bit ALU sits: driven by the cocotb driver/BFM, with `done`/`result` read by the monitor.

## Interface
- `WIDTH`, 8: operand width; must be ≥ 2.
- `MUL_STAGES`, 3: multiply latency in cycles; must be ≥ 1.

- `clk`  in  1: single clock; all logic on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; accepted on a rising edge where `start && ready && op != 3'b000`.
- `A`  in  WIDTH: operand A, sampled at acceptance only.
- `B`  in  WIDTH: operand B, sampled at acceptance only.
- `op`  in  3: opcode, sampled at acceptance only.
- `ready`  out  1: block can accept a request this cycle.
- `done`  out  1: one-cycle pulse; `result`/`err` valid in the same cycle.
- `err`  out  1: qualifies `done`; high for an illegal opcode.
- `result`  out  2*WIDTH: operation result; holds its value until the next `done`.

## Operation
- Opcodes (operands zero-extended to 2*WIDTH, results mod 2^(2*WIDTH)):
  - 000: NOP. Never accepted; no `done`.
  - 001: A+B, carry lands in bit WIDTH.
  - 010: A&B.
  - 011: A^B.
  - 100: A*B, full 2*WIDTH product.
  - 101: A−B, two's-complement wrap. For WIDTH=8, 3−5 = 16'hFFFE.
  - 110: A|B.
  - 111: illegal. `done`=1, `err`=1, `result`=0.
- FSM with two states, IDLE and MUL.
  - IDLE: `ready`=1.
  - Accept of a non-multiply op in IDLE: stay in IDLE.
  - Accept of op 100 with MUL_STAGES>1: go to MUL, load down-counter with MUL_STAGES−2, latch A/B into the multiplier pipeline.
  - MUL: `ready`=0. Counter decrements each cycle. When counter=0 and the product is due, return to IDLE.
  - MUL_STAGES=1: multiply behaves as a single-cycle op; MUL is never entered.
- Multiplier is a MUL_STAGES-deep register pipeline carrying {product, valid}. Only one multiply is in flight at a time.
- `err` is 0 on every `done` except for op 111.
- Reset values: `done`=0, `err`=0, `result`=0, `ready`=1 (state IDLE), multiplier pipeline and counter cleared.
- Reset mid-operation aborts any in-flight multiply. No `done` is produced for it after reset release.
- `start` while `ready`=0 is ignored, not queued. The driver must hold it.

## Timing
- Latency is counted from the accepting edge k.
  - Single-cycle ops (001, 010, 011, 101, 110, 111): `done` high in the cycle after edge k.
  - Multiply: `done` high in the cycle after edge k+MUL_STAGES−1.
- Throughput: one single-cycle op per clock; back-to-back `done` pulses allowed.
- `ready` timing:
  - Drops in the cycle after a multiply accept.
  - Stays low for MUL_STAGES−1 cycles.
  - Is high again in the cycle where the multiply's `done` is high, so a new op can be accepted then.
- `done` is never high for two consecutive cycles from the same request.
- `result` changes only on cycles where `done` is high, or on reset.
- Input changes after acceptance do not affect the in-flight result.
- Reset assertion clears outputs immediately, without waiting for `clk`. The first acceptance can occur on the first rising edge after `reset_n` rises.

## Test plan
- Reset: hold `reset_n`=0 with `start`=1, op=001 → `done`=0, `result`=0, `ready`=1; no `done` after release until a new accept.
- WIDTH=8, back-to-back single-cycle ops, one per cycle:
  - add 8'hFF+8'h01 → 16'h0100
  - and 8'hF0&8'h3C → 16'h0030
  - xor 8'hAA^8'hFF → 16'h0055
  - sub 3−5 → 16'hFFFE
  - or 8'h0F|8'h30 → 16'h003F
  - each `done` exactly 1 cycle after its accept, `err`=0.
- Multiply, MUL_STAGES=3: accept 8'hFF*8'hFF, then change A/B next cycle → `ready` low for 2 cycles; `done` 3 cycles after accept; `result`=16'hFE01; `start` held during `ready`=0 accepted only when `ready` returns.
- Illegal/NOP: op=111 → `done`=1, `err`=1, `result`=0 one cycle later; op=000 with `start`=1 → no `done`, `result` unchanged.
- Reset mid-multiply: accept 8'h10*8'h10, assert `reset_n` low one cycle later → outputs 0 immediately, `ready`=1; no `done` for the aborted multiply after release.
- Parameter sweep: WIDTH=16 with MUL_STAGES=1 and MUL_STAGES=5 → 16'hFFFF*16'hFFFF = 32'hFFFE0001 at latency 1 and 5 respectively; `ready` never low when MUL_STAGES=1.
